// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard unit.
package hazard_pkg;

  // Link register written by jal
  localparam int unsigned DEF_REG_RA = 31;

  // Cycles until a result exists, counted from entry into EX
  localparam int unsigned TNEW_LOAD = 2;
  localparam int unsigned TNEW_ALU  = 1;
  localparam int unsigned TNEW_NONE = 0;

  // Cycles until an operand is consumed, counted from ID
  localparam int unsigned TUSE_BRANCH   = 0;
  localparam int unsigned TUSE_ALU      = 1;
  localparam int unsigned TUSE_STORE_RT = 2;

  // Forwarding mux selects
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

  // How a stage tag register treats the incoming Tnew
  typedef enum logic [1:0] {
    TN_KEEP,
    TN_DEC,
    TN_CLEAR
  } tnew_mode_e;

endpackage

// File: rtl/hazard_unit_stage_tag_reg.sv
// One shadow-pipeline stage: {A3, Tnew, rs, rt} with bubble insertion.
module stage_tag_reg
  import hazard_pkg::*;
#(
  parameter int unsigned TNEW_W = 2,
  parameter tnew_mode_e  MODE   = TN_KEEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_bubble,
  input  logic [4:0]        i_a3,
  input  logic [TNEW_W-1:0] i_tnew,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  output logic [4:0]        o_a3,
  output logic [TNEW_W-1:0] o_tnew,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt
);

  logic [4:0]        r_a3;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [TNEW_W-1:0] r_tnew;
  logic [TNEW_W-1:0] w_tnew_nxt;

  // Tnew as it will be seen one stage later
  always_comb begin
    w_tnew_nxt = i_tnew;
    case (MODE)
      TN_DEC:   w_tnew_nxt = (i_tnew == '0) ? '0 : i_tnew - TNEW_W'(1);
      TN_CLEAR: w_tnew_nxt = '0;
      default:  w_tnew_nxt = i_tnew;
    endcase
  end

  // Tag register; reset and bubble both produce an all-zero (inert) tag
  always_ff @(posedge clk) begin
    if (reset || i_bubble) begin
      r_a3   <= '0;
      r_tnew <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
    end else begin
      r_a3   <= i_a3;
      r_tnew <= w_tnew_nxt;
      r_rs   <= i_rs;
      r_rt   <= i_rt;
    end
  end

  assign o_a3   = r_a3;
  assign o_tnew = r_tnew;
  assign o_rs   = r_rs;
  assign o_rt   = r_rt;

endmodule

// File: rtl/hazard_unit.sv
// Tuse/Tnew stall and forwarding control for the five-stage MIPS pipeline.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_RA = DEF_REG_RA,
  parameter int unsigned TNEW_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rtype_ID,
  input  logic       Itype_ID,
  input  logic       load_ID,
  input  logic       save_ID,
  input  logic       beq_ID,
  input  logic       jal_ID,
  input  logic       jr_ID,
  input  logic       lui_ID,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic [4:0] rd_ID,
  output logic       stall,
  output logic [1:0] FwdRS_ID,
  output logic [1:0] FwdRT_ID,
  output logic [1:0] FwdRS_EX,
  output logic [1:0] FwdRT_EX,
  output logic       FwdRT_MEM
);

  logic [4:0]        w_a3_d;
  logic [TNEW_W-1:0] w_tnew_d;
  logic              w_rd_rs;
  logic              w_rd_rt;
  logic [TNEW_W-1:0] w_tuse_rs;
  logic [TNEW_W-1:0] w_tuse_rt;
  logic              w_stall;

  logic [4:0]        w_a3_e, w_a3_m, w_a3_w;
  logic [TNEW_W-1:0] w_tnew_e, w_tnew_m, w_tnew_w;
  logic [4:0]        w_rs_e, w_rs_m, w_rs_w;
  logic [4:0]        w_rt_e, w_rt_m, w_rt_w;

  // Source fields of MEM/WB tags travel with the tag but are not consumed here
  logic w_unused;
  assign w_unused = ^{w_rs_m, w_rs_w, w_rt_w};

  function automatic logic f_hit(input logic [4:0] src, input logic [4:0] a3);
    return (src != '0) && (src == a3);
  endfunction

  // Nearest producer decides; a matching producer that is not ready blocks
  // older stages (the stall covers that case)
  function automatic logic [1:0] f_sel(input logic hit_e, input logic rdy_e,
                                       input logic hit_m, input logic rdy_m,
                                       input logic hit_w, input logic rdy_w);
    if (hit_e) return rdy_e ? FWD_EX : FWD_NONE;
    if (hit_m) return rdy_m ? FWD_MEM : FWD_NONE;
    if (hit_w && rdy_w) return FWD_WB;
    return FWD_NONE;
  endfunction

  // Destination register and Tnew of the ID instruction
  always_comb begin
    w_a3_d   = '0;
    w_tnew_d = TNEW_W'(TNEW_NONE);
    if (Rtype_ID) begin
      w_a3_d   = rd_ID;
      w_tnew_d = TNEW_W'(TNEW_ALU);
    end else if (Itype_ID) begin
      w_a3_d   = rt_ID;
      w_tnew_d = TNEW_W'(TNEW_ALU);
    end else if (load_ID) begin
      w_a3_d   = rt_ID;
      w_tnew_d = TNEW_W'(TNEW_LOAD);
    end else if (jal_ID) begin
      w_a3_d   = 5'(REG_RA);
      w_tnew_d = TNEW_W'(TNEW_NONE);
    end
  end

  // Which operands the ID instruction reads, and when
  always_comb begin
    w_rd_rs   = 1'b0;
    w_rd_rt   = 1'b0;
    w_tuse_rs = '0;
    w_tuse_rt = '0;
    if (beq_ID || jr_ID) begin
      w_rd_rs   = 1'b1;
      w_tuse_rs = TNEW_W'(TUSE_BRANCH);
    end else if (Rtype_ID || (Itype_ID && !lui_ID) || load_ID || save_ID) begin
      w_rd_rs   = 1'b1;
      w_tuse_rs = TNEW_W'(TUSE_ALU);
    end
    if (beq_ID) begin
      w_rd_rt   = 1'b1;
      w_tuse_rt = TNEW_W'(TUSE_BRANCH);
    end else if (Rtype_ID) begin
      w_rd_rt   = 1'b1;
      w_tuse_rt = TNEW_W'(TUSE_ALU);
    end else if (save_ID) begin
      w_rd_rt   = 1'b1;
      w_tuse_rt = TNEW_W'(TUSE_STORE_RT);
    end
  end

  // Stall when a read operand is needed before its EX/MEM producer delivers it
  always_comb begin
    w_stall = 1'b0;
    if (!reset) begin
      w_stall = (w_rd_rs && f_hit(rs_ID, w_a3_e) && (w_tuse_rs < w_tnew_e)) ||
                (w_rd_rs && f_hit(rs_ID, w_a3_m) && (w_tuse_rs < w_tnew_m)) ||
                (w_rd_rt && f_hit(rt_ID, w_a3_e) && (w_tuse_rt < w_tnew_e)) ||
                (w_rd_rt && f_hit(rt_ID, w_a3_m) && (w_tuse_rt < w_tnew_m));
    end
  end

  // Forwarding selects for the ID comparator, ALU inputs and store data
  always_comb begin
    FwdRS_ID  = FWD_NONE;
    FwdRT_ID  = FWD_NONE;
    FwdRS_EX  = FWD_NONE;
    FwdRT_EX  = FWD_NONE;
    FwdRT_MEM = 1'b0;
    if (!reset) begin
      FwdRS_ID  = f_sel(f_hit(rs_ID, w_a3_e), w_tnew_e == '0,
                        f_hit(rs_ID, w_a3_m), w_tnew_m == '0,
                        f_hit(rs_ID, w_a3_w), w_tnew_w == '0);
      FwdRT_ID  = f_sel(f_hit(rt_ID, w_a3_e), w_tnew_e == '0,
                        f_hit(rt_ID, w_a3_m), w_tnew_m == '0,
                        f_hit(rt_ID, w_a3_w), w_tnew_w == '0);
      FwdRS_EX  = f_sel(1'b0, 1'b0,
                        f_hit(w_rs_e, w_a3_m), w_tnew_m == '0,
                        f_hit(w_rs_e, w_a3_w), w_tnew_w == '0);
      FwdRT_EX  = f_sel(1'b0, 1'b0,
                        f_hit(w_rt_e, w_a3_m), w_tnew_m == '0,
                        f_hit(w_rt_e, w_a3_w), w_tnew_w == '0);
      FwdRT_MEM = f_hit(w_rt_m, w_a3_w);
    end
  end

  assign stall = w_stall;

  stage_tag_reg #(.TNEW_W(TNEW_W), .MODE(TN_KEEP)) u_tag_e (
    .clk(clk), .reset(reset), .i_bubble(w_stall),
    .i_a3(w_a3_d), .i_tnew(w_tnew_d), .i_rs(rs_ID), .i_rt(rt_ID),
    .o_a3(w_a3_e), .o_tnew(w_tnew_e), .o_rs(w_rs_e), .o_rt(w_rt_e)
  );

  stage_tag_reg #(.TNEW_W(TNEW_W), .MODE(TN_DEC)) u_tag_m (
    .clk(clk), .reset(reset), .i_bubble(1'b0),
    .i_a3(w_a3_e), .i_tnew(w_tnew_e), .i_rs(w_rs_e), .i_rt(w_rt_e),
    .o_a3(w_a3_m), .o_tnew(w_tnew_m), .o_rs(w_rs_m), .o_rt(w_rt_m)
  );

  stage_tag_reg #(.TNEW_W(TNEW_W), .MODE(TN_CLEAR)) u_tag_w (
    .clk(clk), .reset(reset), .i_bubble(1'b0),
    .i_a3(w_a3_m), .i_tnew(w_tnew_m), .i_rs(w_rs_m), .i_rt(w_rt_m),
    .o_a3(w_a3_w), .o_tnew(w_tnew_w), .o_rs(w_rs_w), .o_rt(w_rt_w)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random
// instruction streams compared against an instruction-level pipeline model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Rtype_ID, Itype_ID, load_ID, save_ID, beq_ID, jal_ID, jr_ID, lui_ID;
  logic [4:0] rs_ID, rt_ID, rd_ID;
  logic       stall;
  logic [1:0] FwdRS_ID, FwdRT_ID, FwdRS_EX, FwdRT_EX;
  logic       FwdRT_MEM;

  hazard_unit #(.REG_RA(31), .TNEW_W(2)) dut (
    .clk(clk), .reset(reset),
    .Rtype_ID(Rtype_ID), .Itype_ID(Itype_ID), .load_ID(load_ID), .save_ID(save_ID),
    .beq_ID(beq_ID), .jal_ID(jal_ID), .jr_ID(jr_ID), .lui_ID(lui_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
    .stall(stall), .FwdRS_ID(FwdRS_ID), .FwdRT_ID(FwdRT_ID),
    .FwdRS_EX(FwdRS_EX), .FwdRT_EX(FwdRT_EX), .FwdRT_MEM(FwdRT_MEM)
  );

  always #5 clk = ~clk;

  typedef enum {K_NOP, K_ADDU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR} kind_t;
  typedef struct { kind_t k; int rs; int rt; int rd; } ins_t;
  // In-flight instruction: destination, result latency at EX entry, sources
  typedef struct { int dst; int lat; int rs; int rt; } slot_t;
  typedef struct { logic st; logic [1:0] rs_id, rt_id, rs_ex, rt_ex; logic rt_mem; } obs_t;

  slot_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int checks = 0;
  int errors = 0;

  function automatic ins_t mk(kind_t k, int rs, int rt, int rd);
    ins_t i;
    i.k = k; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic int dest_of(ins_t i);
    case (i.k)
      K_ADDU:             return i.rd;
      K_ORI, K_LUI, K_LW: return i.rt;
      K_JAL:              return 31;
      default:            return 0;
    endcase
  endfunction

  function automatic int lat_of(ins_t i);
    case (i.k)
      K_LW:               return 2;
      K_ADDU, K_ORI, K_LUI: return 1;
      default:            return 0;
    endcase
  endfunction

  // -1 means the operand is not read
  function automatic int use_rs(ins_t i);
    case (i.k)
      K_BEQ, K_JR:                return 0;
      K_ADDU, K_ORI, K_LW, K_SW:  return 1;
      default:                    return -1;
    endcase
  endfunction

  function automatic int use_rt(ins_t i);
    case (i.k)
      K_BEQ:   return 0;
      K_ADDU:  return 1;
      K_SW:    return 2;
      default: return -1;
    endcase
  endfunction

  // Cycles still needed before the producer in stage s holds its result
  function automatic int remaining(int s);
    int r;
    if (s == 2) return 0;
    r = pipe[s].lat - s;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic logic model_stall(ins_t i);
    logic res = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (pipe[s].dst != 0) begin
        if (use_rs(i) >= 0 && pipe[s].dst == i.rs && use_rs(i) < remaining(s)) res = 1'b1;
        if (use_rt(i) >= 0 && pipe[s].dst == i.rt && use_rt(i) < remaining(s)) res = 1'b1;
      end
    end
    return res;
  endfunction

  // Youngest producer of src from stage 'first' onward; code = stage index + 1
  function automatic logic [1:0] model_fwd(int src, int first);
    for (int s = first; s < 3; s++) begin
      if (src != 0 && pipe[s].dst == src)
        return (remaining(s) == 0) ? 2'(s + 1) : 2'd0;
    end
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input ins_t i);
    Rtype_ID = (i.k == K_ADDU);
    Itype_ID = (i.k == K_ORI) || (i.k == K_LUI);
    lui_ID   = (i.k == K_LUI);
    load_ID  = (i.k == K_LW);
    save_ID  = (i.k == K_SW);
    beq_ID   = (i.k == K_BEQ);
    jal_ID   = (i.k == K_JAL);
    jr_ID    = (i.k == K_JR);
    rs_ID    = 5'(i.rs);
    rt_ID    = 5'(i.rt);
    rd_ID    = 5'(i.rd);
  endtask

  // One clock: drive ID, check all outputs mid-cycle, advance the model.
  // acc reports whether the model expects the instruction to leave ID.
  task automatic step(input ins_t i, output obs_t o, output logic acc);
    logic es;
    logic [1:0] e_rs_id, e_rt_id, e_rs_ex, e_rt_ex;
    logic e_mem;
    slot_t nw;
    drive(i);
    @(negedge clk);
    if (reset) begin
      es = 1'b0; e_rs_id = '0; e_rt_id = '0; e_rs_ex = '0; e_rt_ex = '0; e_mem = 1'b0;
    end else begin
      es      = model_stall(i);
      e_rs_id = model_fwd(i.rs, 0);
      e_rt_id = model_fwd(i.rt, 0);
      e_rs_ex = model_fwd(pipe[0].rs, 1);
      e_rt_ex = model_fwd(pipe[0].rt, 1);
      e_mem   = (pipe[1].rt != 0) && (pipe[1].rt == pipe[2].dst);
    end
    chk("stall", {1'b0, stall}, {1'b0, es});
    chk("FwdRS_ID", FwdRS_ID, e_rs_id);
    chk("FwdRT_ID", FwdRT_ID, e_rt_id);
    chk("FwdRS_EX", FwdRS_EX, e_rs_ex);
    chk("FwdRT_EX", FwdRT_EX, e_rt_ex);
    chk("FwdRT_MEM", {1'b0, FwdRT_MEM}, {1'b0, e_mem});
    o.st = stall; o.rs_id = FwdRS_ID; o.rt_id = FwdRT_ID;
    o.rs_ex = FwdRS_EX; o.rt_ex = FwdRT_EX; o.rt_mem = FwdRT_MEM;
    acc = !es;
    @(posedge clk);
    nw = '{0, 0, 0, 0};
    if (reset) begin
      pipe[0] = nw; pipe[1] = nw; pipe[2] = nw;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (!es) begin
        nw.dst = dest_of(i); nw.lat = lat_of(i); nw.rs = i.rs; nw.rt = i.rt;
      end
      pipe[0] = nw;
    end
    #1;
  endtask

  // Hold an instruction in ID until it is accepted; returns stall count and
  // the outputs seen in the accepting cycle
  task automatic issue(input ins_t i, output int n, output obs_t o);
    logic acc;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      step(i, o, acc);
      if (acc) return;
      n++;
    end
    checks++;
    errors++;
    $error("FAIL issue_timeout observed=%0d expected=<3", n);
  endtask

  task automatic drain();
    int n;
    obs_t o;
    for (int t = 0; t < 3; t++) issue(mk(K_NOP, 0, 0, 0), n, o);
  endtask

  function automatic int rreg();
    int r = int'($urandom_range(0, 4));
    return (r == 4) ? 31 : r;
  endfunction

  initial begin
    int n;
    obs_t o;
    logic acc;
    kind_t kinds [9];
    kinds = '{K_NOP, K_ADDU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR};
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};

    // Reset held with a load in ID: everything quiet
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step(mk(K_LW, 1, 8, 0), o, acc);
      chk("reset_stall", {1'b0, o.st}, 2'd0);
      chk("reset_fwd", o.rs_id | o.rt_id | o.rs_ex | o.rt_ex, 2'd0);
    end
    reset = 1'b0;

    // lw $8 ; addu $9,$8,$10 : one stall, then WB forward into EX
    issue(mk(K_LW, 1, 8, 0), n, o);
    chk("lw_first_stalls", 2'(n), 2'd0);
    issue(mk(K_ADDU, 8, 10, 9), n, o);
    chk("lw_alu_stalls", 2'(n), 2'd1);
    issue(mk(K_NOP, 0, 0, 0), n, o);
    chk("lw_alu_fwdrs_ex", o.rs_ex, 2'd3);
    drain();

    // addu $8 ; beq $8,$0 : one stall, then MEM forward into ID
    issue(mk(K_ADDU, 1, 2, 8), n, o);
    issue(mk(K_BEQ, 8, 0, 0), n, o);
    chk("alu_beq_stalls", 2'(n), 2'd1);
    chk("alu_beq_fwdrs_id", o.rs_id, 2'd2);
    drain();

    // lw $8 ; beq $8 : two stalls, then WB forward into ID
    issue(mk(K_LW, 1, 8, 0), n, o);
    issue(mk(K_BEQ, 8, 0, 0), n, o);
    chk("lw_beq_stalls", 2'(n), 2'd2);
    chk("lw_beq_fwdrs_id", o.rs_id, 2'd3);
    drain();

    // jal ; jr $31 : no stall, EX forward (PC+8)
    issue(mk(K_JAL, 0, 0, 0), n, o);
    issue(mk(K_JR, 31, 0, 0), n, o);
    chk("jal_jr_stalls", 2'(n), 2'd0);
    chk("jal_jr_fwdrs_id", o.rs_id, 2'd1);
    drain();

    // lw $8 ; sw $8,0($9) : no stall, WB forward of store data in MEM
    issue(mk(K_LW, 1, 8, 0), n, o);
    issue(mk(K_SW, 9, 8, 0), n, o);
    chk("lw_sw_stalls", 2'(n), 2'd0);
    issue(mk(K_NOP, 0, 0, 0), n, o);
    issue(mk(K_NOP, 0, 0, 0), n, o);
    chk("lw_sw_fwdrt_mem", {1'b0, o.rt_mem}, 2'd1);
    drain();

    // ori $0 ; addu $2,$0,$0 : register zero never stalls or forwards
    issue(mk(K_ORI, 1, 0, 0), n, o);
    issue(mk(K_ADDU, 0, 0, 2), n, o);
    chk("r0_stalls", 2'(n), 2'd0);
    chk("r0_fwd_id", o.rs_id | o.rt_id, 2'd0);
    issue(mk(K_NOP, 0, 0, 0), n, o);
    chk("r0_fwd_ex", o.rs_ex | o.rt_ex, 2'd0);
    drain();

    // Reset arriving mid-stall discards the hazard
    issue(mk(K_LW, 1, 8, 0), n, o);
    step(mk(K_ADDU, 8, 10, 9), o, acc);
    chk("pre_reset_stall", {1'b0, o.st}, 2'd1);
    reset = 1'b1;
    step(mk(K_ADDU, 8, 10, 9), o, acc);
    reset = 1'b0;
    step(mk(K_ADDU, 8, 10, 9), o, acc);
    chk("post_reset_stall", {1'b0, o.st}, 2'd0);
    drain();

    // Random instruction stream with occasional resets
    for (int t = 0; t < 600; t++) begin
      ins_t ri;
      ri = mk(kinds[$urandom_range(0, 8)], rreg(), rreg(), rreg());
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        step(ri, o, acc);
        reset = 1'b0;
      end else begin
        issue(ri, n, o);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard unit for the five-stage MIPS core (IF/ID/EX/MEM/WB). It consumes the per-instruction class flags that the ID-stage decoder produces, keeps its own shadow pipeline of destination/readiness tags for EX, MEM and WB, and returns stall and forwarding selects to the datapath. Stall decisions use the Tuse/Tnew model. All forwarding muxes in the datapath are driven from this block.

## Interface

Parameters:
- `REG_RA`, 31, link register written by jal
- `TNEW_W`, 2, width of Tnew counters

Ports (clock and reset are on one clock domain; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `Rtype_ID`  in  1  ID instr is addu/subu
- `Itype_ID`  in  1  ID instr is ori/lui
- `load_ID`  in  1  ID instr is lw
- `save_ID`  in  1  ID instr is sw
- `beq_ID`  in  1  ID instr is beq
- `jal_ID`  in  1  ID instr is jal
- `jr_ID`  in  1  ID instr is jr
- `lui_ID`  in  1  ID instr is lui (no rs read)
- `rs_ID`, `rt_ID`, `rd_ID`  in  5 each  ID instr fields [25:21], [20:16], [15:11]
- `stall`  out  1  freeze PC and IF/ID, bubble ID/EX
- `FwdRS_ID`, `FwdRT_ID`  out  2 each  compare operands in ID: 0 GRF, 1 EX (PC+8), 2 MEM, 3 WB
- `FwdRS_EX`, `FwdRT_EX`  out  2 each  ALU operands: 0 ID/EX reg, 2 MEM, 3 WB
- `FwdRT_MEM`  out  1  sw data: 0 EX/MEM reg, 1 WB

## Operation

- Destination A3: Rtype→rd, Itype/load→rt, jal→REG_RA, else 0. A3=0 never stalls or forwards.
- Tnew on entry to EX: load 2, Rtype/Itype 1, jal 0, others 0.
- Tuse: beq/jr rs,rt 0; Rtype rs,rt 1; Itype (not lui)/load/save rs 1; save rt 2; unread operands never stall.
- stall = 1 iff for an operand read by ID, A3_E or A3_M matches, is nonzero, and Tuse < Tnew of that stage.
- Stage tags {A3, Tnew, rs, rt}: E, M, W. Each clock: W←M (Tnew forced 0), M←E with Tnew−1 saturating at 0, E←decoded ID tag, or bubble (all zero) when stall=1.
- Forward only when A3 matches, nonzero, and that stage Tnew==0; nearest stage wins (EX > MEM > WB). FwdRT_MEM compares rt_M against A3_W.
- Simultaneous match in EX and MEM with EX Tnew>0: stall, no forward from MEM for that cycle (stall covers it).

## Timing

- stall and all Fwd* are combinational from ID inputs and current tags; valid same cycle.
- Tags update on rising clk; one cycle per stage, no other latency.
- Reset: all tags zero; stall=0, all Fwd*=0 in the cycle after reset sampled high, and held while reset is high regardless of ID inputs.
- Reset mid-stall: reset wins; bubble state discarded, no residual stall.
- lw→dependent ALU: exactly one stall cycle. ALU→beq: one stall. lw→beq: two stalls. lw→sw rt: zero stalls.

## Structure

- `hazard_pkg`: Tnew constants (TNEW_LOAD=2, TNEW_ALU=1, TNEW_NONE=0), Tuse constants, forward select codes, REG_RA.
- One sub-module `stage_tag_reg`: sync-reset register for {A3, Tnew, rs, rt} with bubble input and Tnew-decrement option; instantiated for E, M, W.
- Decode of A3/Tuse/Tnew and comparators in top level.

## Test plan

- Reset with load_ID=1, rt_ID=8 held for 3 cycles -> stall=0, all Fwd*=0; after release, tag E has A3=8, Tnew=2.
- lw $8 then addu $9,$8,$10 -> stall=1 for exactly 1 cycle; next cycle addu in EX gets FwdRS_EX=3.
- addu $8 then beq $8,$0 -> 1 stall cycle, then FwdRS_ID=2; lw $8 then beq $8 -> 2 stall cycles, then FwdRS_ID=3.
- jal then jr $31 -> no stall, FwdRS_ID=1 in jr's ID cycle.
- lw $8 then sw $8,0($9) -> no stall; when sw in MEM, FwdRT_MEM=1.
- ori $0,$1,5 then addu $2,$0,$0 -> no stall, all Fwd*=0.
